// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation SAD tracker slice:
// shift-direction encoding, tracker FSM states and common data types.
package me_pkg;

  // Shift direction encoding on the controller's sel bus
  localparam logic [1:0] SEL_DOWN  = 2'd0;  // row + 1
  localparam logic [1:0] SEL_UP    = 2'd1;  // row - 1
  localparam logic [1:0] SEL_RIGHT = 2'd2;  // column + 1
  localparam logic [1:0] SEL_RSVD  = 2'd3;  // reserved, flagged as a protocol error

  // Tracker FSM
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Default geometry (16x16 macroblock in a 48x48 window)
  localparam int DEF_MACRO_DIM  = 16;
  localparam int DEF_SEARCH_DIM = 48;
  localparam int DEF_SAD_W      = 16;
  localparam int DEF_N          = DEF_SEARCH_DIM - DEF_MACRO_DIM;
  localparam int DEF_POS_W      = $clog2(DEF_N);
  localparam int DEF_MV_W       = DEF_POS_W + 1;

  typedef logic signed [DEF_MV_W-1:0] mv_t;
  typedef logic        [DEF_SAD_W-1:0] sad_t;

endpackage

// File: rtl/me_sad_compare.sv
// Combinational candidate compare: raises replace when the new SAD should
// displace the running best. Build option ME_CENTER_PRIORITY_EN breaks SAD
// ties in favour of the candidate closer (L1 distance) to the window centre;
// without it the first-found candidate always wins a tie.
module me_sad_compare
  import me_pkg::*;
#(
  parameter int SAD_W = 16,
  parameter int N     = 32,
  parameter int POS_W = 5
) (
  input  logic [SAD_W-1:0] sad,
  input  logic [SAD_W-1:0] best_sad,
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  input  logic [POS_W-1:0] best_x,
  input  logic [POS_W-1:0] best_y,
  output logic             replace
);

  logic sad_lt;
  logic sad_eq;

  assign sad_lt = (sad < best_sad);
  assign sad_eq = (sad == best_sad);

`ifdef ME_CENTER_PRIORITY_EN
  localparam int PW1 = POS_W + 1;
  localparam logic [POS_W:0] HALF = PW1'(N / 2);

  // Absolute offset of one coordinate from the window centre
  function automatic logic [POS_W:0] center_off(input logic [POS_W-1:0] p);
    logic [POS_W:0] v;
    v = {1'b0, p};
    return (v >= HALF) ? (v - HALF) : (HALF - v);
  endfunction

  logic [POS_W+1:0] dist_new;
  logic [POS_W+1:0] dist_best;

  // Distance of new and stored candidates, then tie-break toward the centre
  always_comb begin
    dist_new  = {1'b0, center_off(pos_x)}  + {1'b0, center_off(pos_y)};
    dist_best = {1'b0, center_off(best_x)} + {1'b0, center_off(best_y)};
    replace   = sad_lt | (sad_eq & (dist_new < dist_best));
  end
`else
  // Positions only matter for the centre tie-break
  logic unused_pos;
  assign unused_pos = ^{pos_x, pos_y, best_x, best_y, sad_eq};

  // Strictly smaller SAD only: first-found candidate keeps ties
  always_comb begin
    replace = sad_lt;
  end
`endif

endmodule

// File: rtl/me_sad_tracker.sv
// Motion-estimation SAD tracker. Snoops the search controller strobes,
// follows the serpentine candidate position, keeps the minimum SAD and its
// motion vector, and pulses done with the final result.
// Build option: ME_CENTER_PRIORITY_EN (centre-biased tie-break, see
// me_sad_compare).
module me_sad_tracker
  import me_pkg::*;
#(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int SAD_W      = 16,
  localparam int N         = SEARCH_DIM - MACRO_DIM,
  localparam int POS_W     = $clog2(N),
  localparam int MV_W      = POS_W + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   en_cpr,
  input  logic                   en_spr,
  input  logic [1:0]             sel,
  input  logic                   valid,
  input  logic [SAD_W-1:0]       sad,
  output logic                   busy,
  output logic                   done,
  output logic [SAD_W-1:0]       best_sad,
  output logic signed [MV_W-1:0] mv_x,
  output logic signed [MV_W-1:0] mv_y,
  output logic                   scan_err
);

  localparam int               CNT_W    = $clog2(N * N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N * N - 1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(N - 1);
  localparam logic [MV_W-1:0]  HALF     = MV_W'(N / 2);

  state_e                 state_q, state_d;
  logic [POS_W-1:0]       pos_x_q, pos_x_d;
  logic [POS_W-1:0]       pos_y_q, pos_y_d;
  logic [CNT_W-1:0]       cand_cnt_q, cand_cnt_d;
  logic                   scan_err_q, scan_err_d;
  // Running minimum during the scan
  logic [SAD_W-1:0]       run_sad_q, run_sad_d;
  logic [POS_W-1:0]       run_x_q, run_x_d;
  logic [POS_W-1:0]       run_y_q, run_y_d;
  // Published result, only refreshed when the search completes
  logic [SAD_W-1:0]       best_sad_q, best_sad_d;
  logic signed [MV_W-1:0] mv_x_q, mv_x_d;
  logic signed [MV_W-1:0] mv_y_q, mv_y_d;

  logic replace;

  me_sad_compare #(
    .SAD_W (SAD_W),
    .N     (N),
    .POS_W (POS_W)
  ) u_compare (
    .sad      (sad),
    .best_sad (run_sad_q),
    .pos_x    (pos_x_q),
    .pos_y    (pos_y_q),
    .best_x   (run_x_q),
    .best_y   (run_y_q),
    .replace  (replace)
  );

  // Next-state, position tracking, running minimum and result capture
  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    cand_cnt_d = cand_cnt_q;
    scan_err_d = scan_err_q;
    run_sad_d  = run_sad_q;
    run_x_d    = run_x_q;
    run_y_d    = run_y_q;
    best_sad_d = best_sad_q;
    mv_x_d     = mv_x_q;
    mv_y_d     = mv_y_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pos_x_d    = '0;
          pos_y_d    = '0;
          cand_cnt_d = '0;
          scan_err_d = 1'b0;
          run_sad_d  = '1;
          run_x_d    = '0;
          run_y_d    = '0;
          state_d    = SEARCH;
        end
      end

      SEARCH: begin
        // Compare uses the current (pre-move) position
        if (valid) begin
          cand_cnt_d = cand_cnt_q + CNT_W'(1);
          if (replace) begin
            run_sad_d = sad;
            run_x_d   = pos_x_q;
            run_y_d   = pos_y_q;
          end
          if (cand_cnt_q == LAST_CNT) begin
            state_d    = DONE;
            best_sad_d = run_sad_d;
            mv_x_d     = {1'b0, run_x_d} - HALF;
            mv_y_d     = {1'b0, run_y_d} - HALF;
          end
        end
        // Shift with en_cpr high is the load phase and does not move
        if (en_spr && !en_cpr) begin
          case (sel)
            SEL_DOWN: begin
              if (pos_y_q == POS_MAX) scan_err_d = 1'b1;
              else                    pos_y_d    = pos_y_q + POS_W'(1);
            end
            SEL_UP: begin
              if (pos_y_q == '0) scan_err_d = 1'b1;
              else               pos_y_d    = pos_y_q - POS_W'(1);
            end
            SEL_RIGHT: begin
              if (pos_x_q == POS_MAX) scan_err_d = 1'b1;
              else                    pos_x_d    = pos_x_q + POS_W'(1);
            end
            default: scan_err_d = 1'b1;
          endcase
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      cand_cnt_q <= '0;
      scan_err_q <= 1'b0;
      run_sad_q  <= '1;
      run_x_q    <= '0;
      run_y_q    <= '0;
      best_sad_q <= '1;
      mv_x_q     <= '0;
      mv_y_q     <= '0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      cand_cnt_q <= cand_cnt_d;
      scan_err_q <= scan_err_d;
      run_sad_q  <= run_sad_d;
      run_x_q    <= run_x_d;
      run_y_q    <= run_y_d;
      best_sad_q <= best_sad_d;
      mv_x_q     <= mv_x_d;
      mv_y_q     <= mv_y_d;
    end
  end

  assign busy     = (state_q == SEARCH);
  assign done     = (state_q == DONE);
  assign best_sad = best_sad_q;
  assign mv_x     = mv_x_q;
  assign mv_y     = mv_y_q;
  assign scan_err = scan_err_q;

endmodule

// File: tb/tb_me_sad_tracker.sv
// Self-checking bench for me_sad_tracker with a 4x8 geometry (N=4, 16
// candidates). Expected results come from a scan-order reference model.
module tb_me_sad_tracker;

  localparam int NN  = 4;
  localparam int SW  = 16;
  localparam int MVW = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           en_cpr = 1'b0;
  logic           en_spr = 1'b0;
  logic [1:0]     sel = 2'd0;
  logic           valid = 1'b0;
  logic [SW-1:0]  sad = '0;
  logic           busy;
  logic           done;
  logic [SW-1:0]  best_sad;
  logic signed [MVW-1:0] mv_x;
  logic signed [MVW-1:0] mv_y;
  logic           scan_err;

  int errors = 0;
  int checks = 0;

  int sad_map [NN][NN];          // indexed [x][y]
  int hold_sad = 'hFFFF;         // result the outputs must currently hold
  int hold_mx  = 0;
  int hold_my  = 0;

  me_sad_tracker #(.MACRO_DIM(4), .SEARCH_DIM(8), .SAD_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en_cpr(en_cpr), .en_spr(en_spr),
    .sel(sel), .valid(valid), .sad(sad), .busy(busy), .done(done),
    .best_sad(best_sad), .mv_x(mv_x), .mv_y(mv_y), .scan_err(scan_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serpentine order: even columns go down, odd columns go up
  function automatic int scan_y(input int k);
    int x = k / NN;
    int r = k % NN;
    return (x % 2 == 0) ? r : (NN - 1 - r);
  endfunction

  function automatic int cdist(input int x, input int y);
    int dx = (x >= NN/2) ? x - NN/2 : NN/2 - x;
    int dy = (y >= NN/2) ? y - NN/2 : NN/2 - y;
    return dx + dy;
  endfunction

  // Reference: minimum over the visit order with the tie rule of the build
  function automatic void model(output int bs, output int bx, output int by);
    bs = 'hFFFF; bx = 0; by = 0;
    for (int k = 0; k < NN*NN; k++) begin
      int x = k / NN;
      int y = scan_y(k);
      int s = sad_map[x][y];
      if (s < bs) begin
        bs = s; bx = x; by = y;
      end
`ifdef ME_CENTER_PRIORITY_EN
      else if (s == bs && cdist(x, y) < cdist(bx, by)) begin
        bs = s; bx = x; by = y;
      end
`endif
    end
  endfunction

  // pre: 0 none, 1 illegal up at row 0, 2 twenty load-phase cycles, 3 reserved sel
  task automatic do_scan(input string name, input int pre, input int mid_start,
                         input int mid_rst);
    int bs, bx, by, gx, gy;
    bit exp_err;
    exp_err = (pre == 1) || (pre == 3);
    model(bs, bx, by);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || scan_err !== 1'b0) begin
      errors++;
      $display("FAIL %s start: busy=%b err=%b exp busy=1 err=0", name, busy, scan_err);
    end
    if (pre == 1 || pre == 3) begin
      en_spr = 1'b1; sel = (pre == 1) ? 2'd1 : 2'd3;
      tick();
      en_spr = 1'b0;
      checks++;
      if (scan_err !== 1'b1) begin
        errors++;
        $display("FAIL %s illegal_step: scan_err=%b exp=1", name, scan_err);
      end
    end else if (pre == 2) begin
      en_cpr = 1'b1; en_spr = 1'b1; sel = 2'd0;
      repeat (20) tick();
      en_cpr = 1'b0; en_spr = 1'b0;
    end
    for (int k = 0; k < NN*NN; k++) begin
      int x = k / NN;
      int r = k % NN;
      valid = 1'b1;
      sad   = SW'(sad_map[x][scan_y(k)]);
      if (r < NN - 1) begin
        en_spr = 1'b1; sel = (x % 2 == 0) ? 2'd0 : 2'd1;
      end else if (x < NN - 1) begin
        en_spr = 1'b1; sel = 2'd2;
      end
      tick();
      valid = 1'b0; en_spr = 1'b0;
      if (k == mid_rst) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || best_sad !== 16'hFFFF ||
            mv_x !== 3'sd0 || mv_y !== 3'sd0 || scan_err !== 1'b0) begin
          errors++;
          $display("FAIL %s async_reset: busy=%b done=%b sad=%0d mv=(%0d,%0d) err=%b exp 0 0 65535 (0,0) 0",
                   name, busy, done, best_sad, mv_x, mv_y, scan_err);
        end
        hold_sad = 'hFFFF; hold_mx = 0; hold_my = 0;
        tick();
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL %s no_done_after_reset: done=%b exp=0", name, done);
        end
        rst_n = 1'b1;
        tick();
        return;
      end
      if (k < NN*NN - 1) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || int'(best_sad) !== hold_sad) begin
          errors++;
          $display("FAIL %s mid k=%0d: done=%b busy=%b sad=%0d exp done=0 busy=1 sad=%0d",
                   name, k, done, busy, best_sad, hold_sad);
        end
      end
      if (k == mid_start) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s start_ignored: busy=%b done=%b exp busy=1 done=0", name, busy, done);
        end
      end
    end
    gx = mv_x; gy = mv_y;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || int'(best_sad) !== bs ||
        gx !== bx - NN/2 || gy !== by - NN/2 || scan_err !== exp_err) begin
      errors++;
      $display("FAIL %s result: done=%b busy=%b sad=%0d mv=(%0d,%0d) err=%b exp done=1 busy=0 sad=%0d mv=(%0d,%0d) err=%b",
               name, done, busy, best_sad, gx, gy, scan_err, bs, bx - NN/2, by - NN/2, exp_err);
    end
    hold_sad = bs; hold_mx = bx - NN/2; hold_my = by - NN/2;
    tick();
    gx = mv_x; gy = mv_y;
    checks++;
    if (done !== 1'b0 || int'(best_sad) !== hold_sad || gx !== hold_mx || gy !== hold_my) begin
      errors++;
      $display("FAIL %s after_done: done=%b sad=%0d mv=(%0d,%0d) exp done=0 sad=%0d mv=(%0d,%0d)",
               name, done, best_sad, gx, gy, hold_sad, hold_mx, hold_my);
    end
    $display("%s: best_sad=%0d mv=(%0d,%0d) scan_err=%b", name, best_sad, gx, gy, scan_err);
  endtask

  task automatic fill(input int v);
    for (int x = 0; x < NN; x++)
      for (int y = 0; y < NN; y++)
        sad_map[x][y] = v;
  endtask

  task automatic fill_rand(input int maxv);
    for (int x = 0; x < NN; x++)
      for (int y = 0; y < NN; y++)
        sad_map[x][y] = int'($urandom_range(maxv, 0));
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || best_sad !== 16'hFFFF ||
        mv_x !== 3'sd0 || mv_y !== 3'sd0 || scan_err !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b sad=%0d mv=(%0d,%0d) err=%b", busy, done, best_sad, mv_x, mv_y, scan_err);
    end
    rst_n = 1'b1;
    tick();
    // valid and shifts while idle must be ignored
    valid = 1'b1; sad = '0; en_spr = 1'b1; sel = 2'd3;
    repeat (3) tick();
    valid = 1'b0; en_spr = 1'b0;
    checks++;
    if (busy !== 1'b0 || best_sad !== 16'hFFFF || scan_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: busy=%b sad=%0d err=%b exp 0 65535 0", busy, best_sad, scan_err);
    end
    $display("reset: outputs at reset values");
  endtask

  task automatic test_serpentine_min();
    fill(100);
    sad_map[2][1] = 7;
    do_scan("serpentine_min", 0, -1, -1);
  endtask

  task automatic test_all_equal();
    fill(50);
    do_scan("all_equal", 0, -1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      fill_rand(15);
      do_scan("random_small", 0, -1, -1);
    end
    fill_rand(65534);
    do_scan("random_wide", 0, -1, -1);
  endtask

  task automatic test_scan_err();
    fill_rand(31);
    do_scan("illegal_up", 1, -1, -1);
    fill_rand(31);
    do_scan("reserved_sel", 3, -1, -1);
  endtask

  task automatic test_load_phase();
    fill(9);
    sad_map[0][0] = 5;
    do_scan("load_phase", 2, -1, -1);
  endtask

  task automatic test_start_mid_search();
    fill_rand(15);
    do_scan("start_mid", 0, 5, -1);
  endtask

  task automatic test_reset_mid_search();
    fill_rand(15);
    do_scan("reset_mid", 0, -1, 7);
    fill_rand(15);
    do_scan("after_reset", 0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_serpentine_min();
    test_all_equal();
    test_random();
    test_scan_err();
    test_load_phase();
    test_start_mid_search();
    test_reset_mid_search();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
